// File: rtl/riscv_keypad_scanner.sv
// 4x4 active-low matrix keypad scanner with press/release debounce.
// Produces {key_valid, key_code} for the memory-mapped IO bridge (0xfffffc08).
module riscv_keypad_scanner #(
  parameter logic [15:0] SCAN_DIV     = 16'd50000,
  parameter logic [7:0]  DEBOUNCE_CNT = 8'd4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col_in,
  output logic [3:0] row_out,
  output logic [4:0] keyboard,
  output logic       key_pulse
);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HOLD, RELEASE} state_t;

  state_t      state, state_n;
  logic [3:0]  sync1, col_s;
  logic [15:0] div;
  logic        tick;
  logic [1:0]  row_idx, row_n;
  logic [1:0]  key_col, col_n;
  logic [7:0]  cnt, cnt_n;
  logic [4:0]  kb_n;
  logic        pulse_n;
  logic        hit;
  logic [1:0]  hit_col;

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0:    key_map = 4'h1;
      4'h1:    key_map = 4'h2;
      4'h2:    key_map = 4'h3;
      4'h3:    key_map = 4'hA;
      4'h4:    key_map = 4'h4;
      4'h5:    key_map = 4'h5;
      4'h6:    key_map = 4'h6;
      4'h7:    key_map = 4'hB;
      4'h8:    key_map = 4'h7;
      4'h9:    key_map = 4'h8;
      4'hA:    key_map = 4'h9;
      4'hB:    key_map = 4'hC;
      4'hC:    key_map = 4'hE;
      4'hD:    key_map = 4'h0;
      4'hE:    key_map = 4'hF;
      default: key_map = 4'hD;
    endcase
  endfunction

  assign tick    = (div == SCAN_DIV - 16'd1);
  assign row_out = ~(4'b0001 << row_idx);

  // Only a single low column counts; multi-key patterns are treated as idle.
  always_comb begin
    hit     = 1'b1;
    hit_col = 2'd0;
    case (col_s)
      4'b1110: hit_col = 2'd0;
      4'b1101: hit_col = 2'd1;
      4'b1011: hit_col = 2'd2;
      4'b0111: hit_col = 2'd3;
      default: hit     = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '1;
      col_s <= '1;
      div   <= '0;
    end else begin
      sync1 <= col_in;
      col_s <= sync1;
      div   <= tick ? '0 : div + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= SCAN;
      row_idx   <= '0;
      key_col   <= '0;
      cnt       <= '0;
      keyboard  <= '0;
      key_pulse <= 1'b0;
    end else begin
      state     <= state_n;
      row_idx   <= row_n;
      key_col   <= col_n;
      cnt       <= cnt_n;
      keyboard  <= kb_n;
      key_pulse <= pulse_n;
    end
  end

  // The row is frozen outside SCAN, so row_idx doubles as the latched key row.
  always_comb begin
    state_n = state;
    row_n   = row_idx;
    col_n   = key_col;
    cnt_n   = cnt;
    kb_n    = keyboard;
    pulse_n = 1'b0;
    if (tick) begin
      case (state)
        SCAN: begin
          if (hit) begin
            col_n   = hit_col;
            cnt_n   = '0;
            state_n = DEBOUNCE;
          end else begin
            row_n = row_idx + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (hit && (hit_col == key_col)) begin
            if (cnt == DEBOUNCE_CNT - 8'd1) begin
              kb_n    = {1'b1, key_map(row_idx, key_col)};
              pulse_n = 1'b1;
              state_n = HOLD;
            end else begin
              cnt_n = cnt + 8'd1;
            end
          end else begin
            state_n = SCAN;
            row_n   = row_idx + 2'd1;
          end
        end
        HOLD: begin
          if (col_s[key_col]) begin
            cnt_n   = '0;
            state_n = RELEASE;
          end
        end
        RELEASE: begin
          if (col_s[key_col]) begin
            if (cnt == DEBOUNCE_CNT - 8'd1) begin
              kb_n[4] = 1'b0;
              state_n = SCAN;
              row_n   = row_idx + 2'd1;
            end else begin
              cnt_n = cnt + 8'd1;
            end
          end else begin
            state_n = HOLD;
          end
        end
        default: state_n = SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_keypad_scanner.sv
// Directed bench for riscv_keypad_scanner with a behavioural keypad matrix model.
module tb_riscv_keypad_scanner;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] col_in;
  logic [3:0] row_out;
  logic [4:0] keyboard;
  logic       key_pulse;

  logic       key_on = 1'b0;
  logic [1:0] key_r = '0;
  logic [1:0] key_c = '0;
  logic       ovr_on = 1'b0;
  logic       ovr_any = 1'b0;
  logic [3:0] ovr_row = 4'hF;
  logic [3:0] ovr_val = 4'hF;

  int unsigned compared = 0;
  int unsigned mismatched = 0;
  int unsigned pulses = 0;

  typedef struct {
    logic [1:0] r;
    logic [1:0] c;
    logic [4:0] code;
  } vec_t;

  riscv_keypad_scanner #(.SCAN_DIV(16'd4), .DEBOUNCE_CNT(8'd3)) dut (
    .clk(clk), .rst(rst), .col_in(col_in), .row_out(row_out),
    .keyboard(keyboard), .key_pulse(key_pulse)
  );

  always #5 clk = ~clk;

  always_comb begin
    col_in = 4'hF;
    if (key_on && !row_out[key_r]) col_in = ~(4'b0001 << key_c);
    if (ovr_on && (ovr_any || row_out == ovr_row)) col_in = ovr_val;
  end

  always @(negedge clk) if (key_pulse === 1'b1) pulses++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] row_code(input int unsigned i);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << (i % 4));
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int unsigned v,
                             input int unsigned lo, input int unsigned hi);
    compared++;
    if (v < lo || v > hi) begin
      mismatched++;
      $display("FAIL %s: got %0d required %0d..%0d", name, v, lo, hi);
    end
  endtask

  task automatic scan_from_reset(input string name, input int unsigned cycles);
    check({name, "_row0"}, row_out, row_code(0));
    for (int unsigned n = 1; n <= cycles; n++) begin
      @(negedge clk);
      check(name, row_out, row_code(n / 4));
    end
  endtask

  task automatic do_press(input logic [1:0] r, input logic [1:0] c, input logic [4:0] code);
    int unsigned n;
    key_r = r; key_c = c; key_on = 1'b1;
    n = 0;
    while (keyboard[4] !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("press_kb", keyboard, code);
  endtask

  task automatic do_release(input logic [1:0] r, input logic [4:0] code);
    int unsigned n;
    logic [1:0] nr;
    key_on = 1'b0;
    n = 0;
    while (keyboard[4] !== 1'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    nr = r + 2'd1;
    check("release_kb", keyboard, {3'b0, 1'b0, code[3:0]});
    check_range("release_latency", n, 15, 18);
    check("release_row", row_out, row_code(nr));
  endtask

  initial begin
    vec_t vecs[8];
    int unsigned p0, run, max_run, n;
    logic [3:0] last_row;
    logic [4:0] kb0;
    logic seen3;

    vecs[0] = '{2'd1, 2'd2, 5'h16};
    vecs[1] = '{2'd0, 2'd0, 5'h11};
    vecs[2] = '{2'd0, 2'd3, 5'h1A};
    vecs[3] = '{2'd1, 2'd3, 5'h1B};
    vecs[4] = '{2'd2, 2'd1, 5'h18};
    vecs[5] = '{2'd3, 2'd0, 5'h1E};
    vecs[6] = '{2'd3, 2'd2, 5'h1F};
    vecs[7] = '{2'd3, 2'd3, 5'h1D};

    // Test 1: reset state and free-running scan
    repeat (3) @(negedge clk);
    check("reset_kb", keyboard, 8'h00);
    check("reset_pulse", key_pulse, 0);
    rst = 1'b0;
    scan_from_reset("idle_row", 40);
    check("idle_kb", keyboard, 8'h00);
    check("idle_pulses", pulses, 0);

    // Test 3: one-tick glitch on row0 aborts debounce
    n = 0;
    while (row_out == 4'b1110 && n < 20) begin @(negedge clk); n++; end
    while (row_out != 4'b1110 && n < 40) begin @(negedge clk); n++; end
    p0 = pulses;
    ovr_any = 1'b1; ovr_val = 4'b1110; ovr_on = 1'b1;
    repeat (4) @(negedge clk);
    ovr_on = 1'b0; ovr_any = 1'b0;
    @(negedge clk);
    check("glitch_debounce_row", row_out, 4'b1110);
    repeat (3) @(negedge clk);
    check("glitch_abort_row", row_out, 4'b1101);
    repeat (20) @(negedge clk);
    check("glitch_kb", keyboard, 8'h00);
    check("glitch_pulses", pulses - p0, 0);

    // Test 2 and key map: table of press/release vectors
    for (int unsigned i = 0; i < 8; i++) begin
      p0 = pulses;
      do_press(vecs[i].r, vecs[i].c, vecs[i].code);
      repeat (20) @(negedge clk);
      check("hold_kb", keyboard, vecs[i].code);
      check("press_pulses", pulses - p0, 1);
      do_release(vecs[i].r, vecs[i].code);
    end

    // Test 4: release bounce during HOLD returns to HOLD
    p0 = pulses;
    do_press(2'd3, 2'd1, 5'h10);
    repeat (8) @(negedge clk);
    key_on = 1'b0;
    repeat (4) @(negedge clk);
    key_on = 1'b1;
    repeat (40) @(negedge clk);
    check("bounce_kb", keyboard, 8'h10);
    check("bounce_pulses", pulses - p0, 1);
    do_release(2'd3, 5'h10);

    // Test 5: two columns low on row2 is not a hit
    kb0 = keyboard;
    p0 = pulses;
    ovr_row = 4'b1011; ovr_val = 4'b1100; ovr_on = 1'b1;
    last_row = row_out; run = 0; max_run = 0; seen3 = 1'b0;
    for (int unsigned k = 0; k < 40; k++) begin
      @(negedge clk);
      if (row_out == last_row) run++; else run = 1;
      if (run > max_run) max_run = run;
      if (row_out == 4'b0111) seen3 = 1'b1;
      last_row = row_out;
    end
    ovr_on = 1'b0;
    check_range("multikey_row_dwell", max_run, 4, 4);
    check("multikey_row3_seen", seen3, 1);
    check("multikey_kb", keyboard, kb0);
    check("multikey_pulses", pulses - p0, 0);

    // Test 6: asynchronous reset while holding a key
    do_press(2'd0, 2'd3, 5'h1A);
    repeat (6) @(negedge clk);
    check("pre_rst_kb", keyboard, 8'h1A);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_kb", keyboard, 8'h00);
    check("async_rst_row", row_out, 4'b1110);
    check("async_rst_pulse", key_pulse, 0);
    key_on = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    scan_from_reset("restart_row", 16);
    check("restart_kb", keyboard, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
